// File: rtl/tff_count_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : tff_count_sequencer_pkg
// Purpose  : Shared types and constants for the T flip-flop count sequencer.
//            Holds the controller state encoding and the count direction
//            constants.
// Revision : 1.0 - initial release
// ============================================================================
package tff_count_sequencer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic MODE_UP   = 1'b1;
    localparam logic MODE_DOWN = 1'b0;

endpackage : tff_count_sequencer_pkg
`default_nettype wire

// File: rtl/tff_count_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : tff_count_sequencer_if
// Purpose  : Control/status bundle between the owning control logic (master)
//            and the count sequencer (slave).
// Ports    : start, mode_up, term, hold, ack  - master -> sequencer
//            count, t_en, busy, done          - sequencer -> master
// Revision : 1.0 - initial release
// ============================================================================
interface tff_count_sequencer_if #(
    parameter int WIDTH = 4
);
    logic             start;
    logic             mode_up;
    logic [WIDTH-1:0] term;
    logic             hold;
    logic             ack;
    logic [WIDTH-1:0] count;
    logic [WIDTH-1:0] t_en;
    logic             busy;
    logic             done;

    modport master (
        output start, mode_up, term, hold, ack,
        input  count, t_en, busy, done
    );

    modport slave (
        input  start, mode_up, term, hold, ack,
        output count, t_en, busy, done
    );
endinterface : tff_count_sequencer_if
`default_nettype wire

// File: rtl/tff_count_sequencer_cell.sv
`default_nettype none
// ============================================================================
// Module   : tff_cell
// Purpose  : Single T flip-flop. q toggles on the rising clock edge when t=1
//            and holds otherwise.
// Ports    : clock - rising-edge clock
//            reset - asynchronous active-low reset (q -> 0)
//            t     - toggle enable
//            q     - flip-flop output
// Revision : 1.0 - initial release
// ============================================================================
module tff_cell (
    input  wire logic clock,
    input  wire logic reset,
    input  wire logic t,
    output logic      q
);

    logic r_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_q <= 1'b0;
        end else if (t) begin
            r_q <= ~r_q;
        end
    end

    assign q = r_q;

endmodule : tff_cell
`default_nettype wire

// File: rtl/tff_count_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tff_count_sequencer
// Purpose  : Sequences a WIDTH-bit counter built from T flip-flop cells.
//            Clears to the start value, counts up or down one step per cycle
//            (frozen by hold) and stops at a programmed terminal value, with a
//            start/done/ack handshake.
// Ports    : clock - rising-edge clock
//            reset - asynchronous active-low reset
//            bus   - slave side of tff_count_sequencer_if
//                    (start, mode_up, term, hold, ack in;
//                     count, t_en, busy, done out)
// Revision : 1.0 - initial release
// ============================================================================
module tff_count_sequencer
    import tff_count_sequencer_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  wire logic               clock,
    input  wire logic               reset,
    tff_count_sequencer_if.slave    bus
);

    state_t           r_state;
    state_t           w_state_next;
    logic [WIDTH-1:0] r_term_q;
    logic             r_mode_q;

    logic [WIDTH-1:0] w_count;
    logic [WIDTH-1:0] w_t_en;
    logic [WIDTH-1:0] w_sv;
    logic [WIDTH-1:0] w_match;
    logic [WIDTH-1:0] w_step;
    logic             w_at_term;

    // Start value: all-zeros for up, all-ones for down.
    assign w_sv      = (r_mode_q == MODE_DOWN) ? '1 : '0;
    assign w_at_term = (w_count == r_term_q);

    // A bit toggles on a step when every lower bit is 1 (up) or 0 (down).
    // Inverting the count for down mode lets one AND-prefix serve both.
    assign w_match = (r_mode_q == MODE_UP) ? w_count : ~w_count;

    for (genvar i = 0; i < WIDTH; i++) begin : g_step
        if (i == 0) begin : g_lsb
            assign w_step[i] = 1'b1;
        end else begin : g_upper
            assign w_step[i] = &w_match[i-1:0];
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state  <= IDLE;
            r_term_q <= '0;
            r_mode_q <= MODE_UP;
        end else begin
            r_state <= w_state_next;
            if (r_state == IDLE && bus.start) begin
                r_term_q <= bus.term;
                r_mode_q <= bus.mode_up;
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_t_en       = '0;
        case (r_state)
            IDLE: begin
                if (bus.start) begin
                    w_state_next = CLEAR;
                end
            end
            CLEAR: begin
                // Toggle exactly the bits that differ from the start value.
                w_t_en       = w_count ^ w_sv;
                w_state_next = RUN;
            end
            RUN: begin
                // Terminal check wins over hold.
                if (w_at_term) begin
                    w_state_next = DONE;
                end else if (!bus.hold) begin
                    w_t_en = w_step;
                end
            end
            DONE: begin
                if (bus.ack) begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        tff_cell u_cell (
            .clock (clock),
            .reset (reset),
            .t     (w_t_en[i]),
            .q     (w_count[i])
        );
    end

    assign bus.count = w_count;
    assign bus.t_en  = w_t_en;
    assign bus.busy  = (r_state == CLEAR) || (r_state == RUN);
    assign bus.done  = (r_state == DONE);

endmodule : tff_count_sequencer
`default_nettype wire

// File: tb/tb_tff_count_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_tff_count_sequencer
// Purpose  : Self-checking bench for tff_count_sequencer. Directed runs plus
//            randomized runs; a scoreboard records the cycle and value at
//            which each run must complete and a monitor checks it on done.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tff_count_sequencer;

    localparam int W = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc   = 0;
    int   tests = 0;
    int   fails = 0;

    // Counter value the previous run left behind (model side).
    logic [W-1:0] m_count = '0;

    typedef struct {
        int           cyc;
        logic [W-1:0] cnt;
    } exp_t;

    exp_t sb[$];

    tff_count_sequencer_if #(.WIDTH(W)) ctl ();

    tff_count_sequencer #(.WIDTH(W)) dut (
        .clock (clk),
        .reset (rst_n),
        .bus   (ctl)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: on each rising done, pop the expected completion and compare.
    initial begin : monitor
        exp_t e;
        bit   prev;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (ctl.done === 1'b1 && !prev) begin
                if (sb.size() == 0) begin
                    chk("unexpected_done", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk("done_cycle", cyc, e.cyc);
                    chk("done_value", ctl.count, e.cnt);
                end
            end
            prev = (ctl.done === 1'b1);
        end
    end

    // One complete run. hmode: 0 no hold, 1 random hold, 2 hold twice at count 1
    // and at the terminal value.
    task automatic do_run(input logic m, input logic [W-1:0] t, input int hmode);
        logic [W-1:0] sv, cnt, nxt, exp_en;
        bit           hp[$];
        bit           h;
        int           n1, nh, diff, k;
        exp_t         e;

        sv  = m ? '0 : '1;
        cnt = sv;
        nh  = 0;
        n1  = 0;
        while (cnt != t) begin
            if (hmode == 1)      h = ($urandom_range(0, 3) == 0);
            else if (hmode == 2) h = (cnt == 1 && n1 < 2);
            else                 h = 1'b0;
            if (h) begin
                nh++;
                n1++;
            end else begin
                cnt = m ? cnt + 1'b1 : cnt - 1'b1;
            end
            hp.push_back(h);
        end
        diff = m ? int'(t) : int'(sv) - int'(t);

        @(posedge clk); #1;
        chk("idle_busy", ctl.busy, 0);
        chk("idle_count", ctl.count, m_count);
        e.cyc = cyc + 3 + diff + nh;
        e.cnt = t;
        sb.push_back(e);
        ctl.start   = 1'b1;
        ctl.mode_up = m;
        ctl.term    = t;
        ctl.hold    = 1'($urandom_range(0, 1));
        @(negedge clk);
        chk("idle_t_en", ctl.t_en, 0);

        @(posedge clk); #1;
        ctl.start   = 1'b0;
        ctl.mode_up = 1'($urandom_range(0, 1));
        ctl.term    = W'($urandom);
        ctl.hold    = 1'($urandom_range(0, 1));
        @(negedge clk);
        chk("clear_busy", ctl.busy, 1);
        chk("clear_t_en", ctl.t_en, m_count ^ sv);

        cnt = sv;
        for (int it = 0; it < 64; it++) begin
            @(posedge clk); #1;
            if (cnt != t) h = hp.pop_front();
            else          h = (hmode == 2) ? 1'b1 : 1'($urandom_range(0, 1));
            ctl.hold    = h;
            ctl.start   = ($urandom_range(0, 3) == 0);
            ctl.mode_up = 1'($urandom_range(0, 1));
            ctl.term    = W'($urandom);
            @(negedge clk);
            nxt    = m ? cnt + 1'b1 : cnt - 1'b1;
            exp_en = (cnt == t || h) ? '0 : (cnt ^ nxt);
            chk("run_count", ctl.count, cnt);
            chk("run_t_en", ctl.t_en, exp_en);
            chk("run_busy", ctl.busy, 1);
            if (cnt == t) break;
            if (!h) cnt = nxt;
        end

        ctl.hold = 1'b0;
        k = $urandom_range(0, 2);
        for (int i = 0; i <= k; i++) begin
            @(posedge clk); #1;
            ctl.start = 1'($urandom_range(0, 1));
            ctl.ack   = (i == k);
            ctl.term  = W'($urandom);
            @(negedge clk);
            chk("done_flag", ctl.done, 1);
            chk("done_count", ctl.count, t);
            chk("done_t_en", ctl.t_en, 0);
            chk("done_busy", ctl.busy, 0);
        end

        @(posedge clk); #1;
        ctl.ack   = 1'b0;
        ctl.start = 1'b0;
        @(negedge clk);
        chk("post_ack_done", ctl.done, 0);
        chk("post_ack_busy", ctl.busy, 0);
        chk("post_ack_count", ctl.count, t);
        @(posedge clk); #1;
        @(negedge clk);
        chk("no_restart_busy", ctl.busy, 0);
        m_count = t;
    endtask

    task automatic reset_midrun();
        int i;
        @(posedge clk); #1;
        ctl.start   = 1'b1;
        ctl.mode_up = 1'b1;
        ctl.term    = 4'd10;
        ctl.hold    = 1'b0;
        @(posedge clk); #1;
        ctl.start = 1'b0;
        for (i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (ctl.count == 4'd6) break;
        end
        chk("reach_6", ctl.count, 6);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_count", ctl.count, 0);
        chk("async_rst_busy", ctl.busy, 0);
        chk("async_rst_done", ctl.done, 0);
        chk("async_rst_t_en", ctl.t_en, 0);
        @(negedge clk);
        rst_n = 1'b1;
        m_count = '0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("after_rst_busy", ctl.busy, 0);
        chk("after_rst_count", ctl.count, 0);
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        ctl.start   = 1'b0;
        ctl.mode_up = 1'b0;
        ctl.term    = '0;
        ctl.hold    = 1'b0;
        ctl.ack     = 1'b0;
        rst_n       = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_count", ctl.count, 0);
        chk("reset_busy", ctl.busy, 0);
        chk("reset_done", ctl.done, 0);
        chk("reset_t_en", ctl.t_en, 0);
        rst_n = 1'b1;

        do_run(1'b1, 4'd5, 0);
        do_run(1'b0, 4'd12, 0);
        do_run(1'b1, 4'd3, 2);
        do_run(1'b1, 4'd0, 1);
        do_run(1'b0, 4'd15, 0);
        reset_midrun();
        do_run(1'b1, 4'd15, 0);

        for (int r = 0; r < 25; r++) begin
            do_run(1'($urandom_range(0, 1)), W'($urandom), $urandom_range(0, 1));
        end

        repeat (4) @(posedge clk);
        #1;
        chk("scoreboard_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_tff_count_sequencer
`default_nettype wire

// File: doc/tff_count_sequencer.md
Name: tff_count_sequencer

Overview:
- Controller that sequences a WIDTH-bit counter built only from T flip-flops.
- Generates the per-bit toggle enables for clear-to-start, up-count, down-count and hold, and stops at a programmed terminal value.
- Uses a start/done/ack handshake toward the owning control logic.
- Replaces hand-derived fixed toggle equations with one reusable, run-time-programmable sequencer.

Parameters:
WIDTH  4  counter width in bits (T flip-flop cells), >= 2

Ports:
clock    input   1      rising-edge clock
reset    input   1      asynchronous, active-low reset
start    input   1      pulse; sampled only in IDLE; begins a count run
mode_up  input   1      sampled with start: 1 = count up from 0, 0 = count down from all-ones
term     input   WIDTH  terminal value, sampled with start
hold     input   1      in RUN, freezes count (all toggle enables 0)
ack      input   1      in DONE, acknowledges completion
count    output  WIDTH  current counter value (T flip-flop outputs)
t_en     output  WIDTH  toggle enables driven into the cells this cycle
busy     output  1      1 in CLEAR or RUN
done     output  1      1 in DONE

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; count=0; term_q=0; mode_q=1.
  - busy=0, done=0, t_en=0 while in reset.
  - Takes effect mid-run with no completion pulse.
- t_en is combinational from state, count, mode_q and hold. Each cell toggles its bit at the clock edge when its t_en bit is 1.
- IDLE:
  - t_en=0.
  - On start=1: latch term_q<=term and mode_q<=mode_up, then go to CLEAR.
- CLEAR (exactly 1 cycle):
  - t_en = count XOR sv, where sv = 0 if mode_q=1, else all-ones.
  - Next edge: count=sv, state=RUN.
- RUN:
  - If count==term_q: t_en=0, next state DONE. This applies even if hold=1.
  - Else if hold=1: t_en=0, stay in RUN.
  - Else if mode_q=1 (up): t_en[0]=1; t_en[i]=AND(count[i-1:0]).
  - Else (down): t_en[0]=1; t_en[i]=AND(~count[i-1:0]).
  - No wrap-around occurs: terminal detection always precedes wrap, because any term_q is reached before the count passes all-ones (up) or 0 (down).
- DONE:
  - t_en=0; count holds the terminal value.
  - On ack=1: go to IDLE next edge; count is retained.
  - start is ignored in DONE, including when start and ack are 1 in the same cycle.
- start outside IDLE is ignored. ack outside DONE is ignored.
- Latency, with the start edge as edge 0:
  - CLEAR during cycle 1; RUN with count=sv at edge 2.
  - done rises at edge 3 + |term_q - sv|, plus one extra edge per RUN cycle with hold=1 and count!=term_q.
  - If term_q==sv, done rises at edge 3.
- Output decode: busy = (state==CLEAR or state==RUN); done = (state==DONE). Both are registered-state decodes with no combinational path from inputs.

Decomposition:
- Shared package:
  - state encoding IDLE=2'd0, CLEAR=2'd1, RUN=2'd2, DONE=2'd3;
  - mode constants MODE_UP=1'b1, MODE_DOWN=1'b0.
- Sub-module tff_cell, instantiated WIDTH times:
  - ports clock, reset, t, q;
  - single T flip-flop, rising edge, asynchronous active-low reset to 0;
  - q toggles when t=1 and holds otherwise.
- The top level holds the FSM, term_q/mode_q registers, the terminal comparator and the t_en logic.

Test Plan:
- Up run: reset, count=0. start=1, mode_up=1, term=5 for one cycle. → count sequence 0,0,1,2,3,4,5. done=1 at edge 8 and held. Then ack=1 → IDLE next edge, count stays 5.
- Down run after a prior up run left count=5: start, mode_up=0, term=12. → CLEAR edge gives count=15 (t_en=4'b1010 in CLEAR). Then 14,13,12; done at edge 6.
- Hold: up run, term=3, hold=1 for 2 cycles while count=1. → count stays 1 for 2 cycles, t_en=0; done at edge 8. With hold asserted at count==term, done still rises on the next edge.
- term equals start value: up run with term=0 → done at edge 3, no toggles in RUN.
- Ignored inputs:
  - start pulses during RUN → no effect on count or term_q.
  - In DONE, start=1 and ack=1 together → IDLE next edge, no new run.
  - Next start in IDLE → normal run.
- Reset mid-run: reset=0 asynchronously at count=6 of an up run to term=10 → count=0, busy=0, done=0 immediately, without a clock edge. Release reset → IDLE, awaiting start.
